// File: rtl/microcode_sequencer.sv
// T-state sequencer and microcode decoder for the 8-bit SAP-style CPU.
// Stage/halt/counter advance on the rising edge; the control word is registered on the falling edge.
module microcode_sequencer #(
   parameter int unsigned OPCODE_W   = 4,
   parameter int unsigned NUM_STAGES = 6,
   parameter bit          EARLY_END  = 1'b1,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                step_mode,
   input  logic                step,
   output logic [14:0]         ctrl,
   output logic [2:0]          stage,
   output logic                halted,
   output logic                instr_done,
   output logic [CNT_W-1:0]    instr_count
);

   localparam logic [14:0] CtrlIdle = 15'h0FE3;

   localparam int unsigned BitPcInc     = 14;
   localparam int unsigned BitPcEn      = 13;
   localparam int unsigned BitPcLoad    = 12;
   localparam int unsigned BitMarAddrN  = 11;
   localparam int unsigned BitRamEnN    = 9;
   localparam int unsigned BitRamLoadN  = 8;
   localparam int unsigned BitIrLoadN   = 7;
   localparam int unsigned BitIrEnN     = 6;
   localparam int unsigned BitRegaLoadN = 5;
   localparam int unsigned BitRegaEn    = 4;
   localparam int unsigned BitAdderSub  = 3;
   localparam int unsigned BitRegbEn    = 2;
   localparam int unsigned BitRegbLoadN = 1;
   localparam int unsigned BitOutLoadN  = 0;

   localparam logic [OPCODE_W-1:0] OpHlt = OPCODE_W'(0);
   localparam logic [OPCODE_W-1:0] OpAdd = OPCODE_W'(2);
   localparam logic [OPCODE_W-1:0] OpSub = OPCODE_W'(3);
   localparam logic [OPCODE_W-1:0] OpLda = OPCODE_W'(4);
   localparam logic [OPCODE_W-1:0] OpOut = OPCODE_W'(5);
   localparam logic [OPCODE_W-1:0] OpSta = OPCODE_W'(6);
   localparam logic [OPCODE_W-1:0] OpJmp = OPCODE_W'(7);

   localparam logic [2:0] StHold = 3'd7;

   logic [2:0]       stage_q, stage_d;
   logic             halted_q, halted_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [14:0]      ctrl_q, ctrl_d;
   logic [2:0]       last_stage;
   logic             adv, is_end, is_illegal;

   assign adv        = !step_mode || step;
   assign is_illegal = (stage_q != StHold) && (32'(stage_q) >= NUM_STAGES);

   always_comb begin
      last_stage = 3'd2;
      case (opcode)
         OpLda, OpSta: last_stage = 3'd4;
         OpAdd, OpSub: last_stage = 3'd5;
         OpOut, OpJmp: last_stage = 3'd3;
         OpHlt:        last_stage = StHold; // HLT never completes
         default:      last_stage = 3'd2;
      endcase
      if (!EARLY_END && opcode != OpHlt) last_stage = 3'(NUM_STAGES - 1);
   end

   assign is_end     = !halted_q && !is_illegal && (stage_q == last_stage);
   assign instr_done = is_end && adv;

   always_comb begin
      stage_d  = stage_q;
      halted_d = halted_q;
      count_d  = count_q;
      if (halted_q) begin
         stage_d = stage_q;
      end else if (stage_q == StHold) begin
         stage_d = 3'd0;
      end else if (is_illegal) begin
         stage_d = StHold;
      end else if (adv) begin
         if (stage_q == 3'd3 && opcode == OpHlt) begin
            halted_d = 1'b1;
         end else if (is_end) begin
            stage_d = 3'd0;
            count_d = count_q + CNT_W'(1);
         end else begin
            stage_d = stage_q + 3'd1;
         end
      end
   end

   // Micro-ops only fire on an advancing edge, so a held stage never repeats a load.
   always_comb begin
      ctrl_d = CtrlIdle;
      if (adv && !halted_q && !is_illegal) begin
         case (stage_q)
            3'd0: begin
               ctrl_d[BitPcEn]     = 1'b1;
               ctrl_d[BitMarAddrN] = 1'b0;
            end
            3'd1: ctrl_d[BitPcInc] = 1'b1;
            3'd2: begin
               ctrl_d[BitRamEnN]  = 1'b0;
               ctrl_d[BitIrLoadN] = 1'b0;
            end
            3'd3: begin
               case (opcode)
                  OpLda, OpAdd, OpSub, OpSta: begin
                     ctrl_d[BitIrEnN]    = 1'b0;
                     ctrl_d[BitMarAddrN] = 1'b0;
                  end
                  OpOut: begin
                     ctrl_d[BitRegaEn]   = 1'b1;
                     ctrl_d[BitOutLoadN] = 1'b0;
                  end
                  OpJmp: begin
                     ctrl_d[BitIrEnN]  = 1'b0;
                     ctrl_d[BitPcLoad] = 1'b1;
                  end
                  default: ;
               endcase
            end
            3'd4: begin
               case (opcode)
                  OpLda: begin
                     ctrl_d[BitRamEnN]    = 1'b0;
                     ctrl_d[BitRegaLoadN] = 1'b0;
                  end
                  OpAdd, OpSub: begin
                     ctrl_d[BitRamEnN]    = 1'b0;
                     ctrl_d[BitRegbLoadN] = 1'b0;
                     ctrl_d[BitAdderSub]  = (opcode == OpSub);
                  end
                  OpSta: begin
                     ctrl_d[BitRegaEn]   = 1'b1;
                     ctrl_d[BitRamLoadN] = 1'b0;
                  end
                  default: ;
               endcase
            end
            3'd5: begin
               if (opcode == OpAdd || opcode == OpSub) begin
                  ctrl_d[BitRegbEn]    = 1'b1;
                  ctrl_d[BitRegaLoadN] = 1'b0;
                  ctrl_d[BitAdderSub]  = (opcode == OpSub);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stage_q  <= StHold;
         halted_q <= 1'b0;
         count_q  <= '0;
      end else begin
         stage_q  <= stage_d;
         halted_q <= halted_d;
         count_q  <= count_d;
      end
   end

   always_ff @(negedge clk) begin
      if (!rst_n) ctrl_q <= CtrlIdle;
      else        ctrl_q <= ctrl_d;
   end

   assign ctrl        = ctrl_q;
   assign stage       = stage_q;
   assign halted      = halted_q;
   assign instr_count = count_q;

endmodule
